mdc_twiddle_gen: RTL and testbench

- Twiddle sequencer that sits directly upstream of the complex multiplier in the 32-point radix-2 MDC FFT.
- Counts samples on the lower (multiplied) branch after butterfly stage STAGE, looks up W32^e, and registers data, twiddle and mul_mode together so the multiplier sees them in the same cycle.
- Drives bypass (mul_mode=1) when e=0, so the multiplier's twiddle port never has to represent 1.0.

---
 rtl/fft_pkg.sv | 17 +
 rtl/mdc_twiddle_gen_twiddle_rom.sv | 66 ++++++
 rtl/mdc_twiddle_gen.sv | 90 +++++++++
 tb/tb_mdc_twiddle_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 32-point radix-2 MDC FFT datapath.
//   FFT_N    : transform size
//   FFT_HALF : samples per frame on one MDC branch
//   CNT_W    : width of the per-branch sample counter
//   tw_scale : fixed-point scale of a twiddle factor for a given data width
package fft_pkg;

    localparam int unsigned FFT_N    = 32;
    localparam int unsigned FFT_HALF = 16;
    localparam int unsigned CNT_W    = 4;

    // Twiddle unity: two bits of headroom below the data width.
    function automatic int unsigned tw_scale(input int unsigned width);
        return 32'(1) << (width - 2);
    endfunction

endpackage

// File: rtl/mdc_twiddle_gen_twiddle_rom.sv
// Combinational 16-entry W32^e lookup, e = 0..15.
//   e      : twiddle exponent
//   rom_re : round(S*cos(2*pi*e/32)), S = tw_scale(WIDTH)
//   rom_im : -round(S*sin(2*pi*e/32))
// Entries are derived from WIDTH at elaboration; e=0 yields re=0 because +S
// is not representable in WIDTH-1 bits and the multiplier bypasses that case.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic        [CNT_W-1:0] e,
    output logic signed [WIDTH-2:0] rom_re,
    output logic signed [WIDTH-2:0] rom_im
);

    // cos(k*pi/16) for k = 0..8 in Q30; covers the first quarter wave.
    function automatic longint cos_q30(input int unsigned k);
        case (k)
            0:       return 64'sd1073741824;
            1:       return 64'sd1053110175;
            2:       return 64'sd992008094;
            3:       return 64'sd892783698;
            4:       return 64'sd759250125;
            5:       return 64'sd596539005;
            6:       return 64'sd410903207;
            7:       return 64'sd209476638;
            default: return 64'sd0;
        endcase
    endfunction

    // Rescale a non-negative Q30 value to the twiddle grid, rounding half up.
    function automatic longint to_grid(input longint q30);
        longint scale;
        scale = longint'(tw_scale(WIDTH));
        return (q30 * scale + (64'sd1 <<< 29)) >>> 30;
    endfunction

    function automatic logic signed [WIDTH-2:0] tw_re(input int unsigned idx);
        longint m;
        if (idx <= 8) m = to_grid(cos_q30(idx));
        else          m = -to_grid(cos_q30(16 - idx));
        if (m == longint'(tw_scale(WIDTH))) m = 0;
        return (WIDTH-1)'(m);
    endfunction

    // sin(e*pi/16) is non-negative over e = 0..15 and mirrors around e = 8.
    function automatic logic signed [WIDTH-2:0] tw_im(input int unsigned idx);
        longint m;
        if (idx <= 8) m = -to_grid(cos_q30(8 - idx));
        else          m = -to_grid(cos_q30(idx - 8));
        return (WIDTH-1)'(m);
    endfunction

    logic signed [WIDTH-2:0] re_tab [FFT_HALF];
    logic signed [WIDTH-2:0] im_tab [FFT_HALF];

    for (genvar i = 0; i < int'(FFT_HALF); i++) begin : g_tab
        assign re_tab[i] = tw_re(i);
        assign im_tab[i] = tw_im(i);
    end

    assign rom_re = re_tab[e];
    assign rom_im = im_tab[e];

endmodule

// File: rtl/mdc_twiddle_gen.sv
// Twiddle sequencer in front of the complex multiplier after butterfly
// stage STAGE of the 32-point MDC FFT. Counts lower-branch samples, forms
// e = (k mod (16>>STAGE)) << STAGE and registers data, twiddle and mode
// together with one cycle of latency.
//   clk, rst_n        : clock, async active-low reset
//   in_valid, in_sof  : sample valid, frame start (qualified by in_valid)
//   in_re, in_im      : lower-branch sample
//   x0_re, x0_im      : registered sample to the multiplier
//   rom_re, rom_im    : registered twiddle W32^e
//   mul_mode          : 0 = multiply, 1 = bypass (e == 0)
//   out_valid, out_sof: registered valid / frame start
module mdc_twiddle_gen
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned N     = 32,
    parameter int unsigned STAGE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic signed [WIDTH-1:0] x0_re,
    output logic signed [WIDTH-1:0] x0_im,
    output logic signed [WIDTH-2:0] rom_re,
    output logic signed [WIDTH-2:0] rom_im,
    output logic                    mul_mode,
    output logic                    out_valid,
    output logic                    out_sof
);

    if (N != FFT_N) begin : g_bad_n
        $error("mdc_twiddle_gen: N must be 32");
    end
    if (STAGE > 3) begin : g_bad_stage
        $error("mdc_twiddle_gen: STAGE must be 0..3");
    end

    localparam int unsigned     SPAN = FFT_HALF >> STAGE;
    localparam logic [CNT_W-1:0] MASK = CNT_W'(SPAN - 1);

    logic        [CNT_W-1:0] k;
    logic        [CNT_W-1:0] idx_c;
    logic        [CNT_W-1:0] e_c;
    logic signed [WIDTH-2:0] tw_re_c;
    logic signed [WIDTH-2:0] tw_im_c;

    // Frame start overrides the counter, also forcing a mid-frame resync.
    always_comb begin
        idx_c = k;
        if (in_valid && in_sof) idx_c = '0;
        e_c = (idx_c & MASK) << STAGE;
    end

    twiddle_rom #(
        .WIDTH (WIDTH)
    ) u_rom (
        .e      (e_c),
        .rom_re (tw_re_c),
        .rom_im (tw_im_c)
    );

    // Counter and output registers; payload holds when no sample arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            x0_re     <= '0;
            x0_im     <= '0;
            rom_re    <= '0;
            rom_im    <= '0;
            mul_mode  <= 1'b1;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_sof   <= in_valid & in_sof;
            if (in_valid) begin
                k        <= idx_c + CNT_W'(1);
                x0_re    <= in_re;
                x0_im    <= in_im;
                rom_re   <= tw_re_c;
                rom_im   <= tw_im_c;
                mul_mode <= (e_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_mdc_twiddle_gen.sv
// Directed bench for mdc_twiddle_gen: three instances (STAGE 0, 1, 3) share
// one stimulus stream; expected twiddles come from a hand-computed table.
module tb_mdc_twiddle_gen;

    localparam int unsigned W = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_sof;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;

    logic signed [W-1:0] s0_x0_re, s0_x0_im, s1_x0_re, s1_x0_im, s3_x0_re, s3_x0_im;
    logic signed [W-2:0] s0_rom_re, s0_rom_im, s1_rom_re, s1_rom_im, s3_rom_re, s3_rom_im;
    logic s0_mm, s0_ov, s0_os, s1_mm, s1_ov, s1_os, s3_mm, s3_ov, s3_os;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdc_twiddle_gen #(.WIDTH(W), .N(32), .STAGE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .x0_re(s0_x0_re), .x0_im(s0_x0_im),
        .rom_re(s0_rom_re), .rom_im(s0_rom_im), .mul_mode(s0_mm),
        .out_valid(s0_ov), .out_sof(s0_os)
    );

    mdc_twiddle_gen #(.WIDTH(W), .N(32), .STAGE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .x0_re(s1_x0_re), .x0_im(s1_x0_im),
        .rom_re(s1_rom_re), .rom_im(s1_rom_im), .mul_mode(s1_mm),
        .out_valid(s1_ov), .out_sof(s1_os)
    );

    mdc_twiddle_gen #(.WIDTH(W), .N(32), .STAGE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .x0_re(s3_x0_re), .x0_im(s3_x0_im),
        .rom_re(s3_rom_re), .rom_im(s3_rom_im), .mul_mode(s3_mm),
        .out_valid(s3_ov), .out_sof(s3_os)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // round(256*cos(2*pi*e/32)); e=0 is 0 since +256 does not fit 9 bits.
    function automatic int exp_re(input int e);
        case (e)
            0: return 0;       1: return 251;     2: return 237;     3: return 213;
            4: return 181;     5: return 142;     6: return 98;      7: return 50;
            8: return 0;       9: return -50;     10: return -98;    11: return -142;
            12: return -181;   13: return -213;   14: return -237;   default: return -251;
        endcase
    endfunction

    // -round(256*sin(2*pi*e/32))
    function automatic int exp_im(input int e);
        case (e)
            0: return 0;       1: return -50;     2: return -98;     3: return -142;
            4: return -181;    5: return -213;    6: return -237;    7: return -251;
            8: return -256;    9: return -251;    10: return -237;   11: return -213;
            12: return -181;   13: return -142;   14: return -98;    default: return -50;
        endcase
    endfunction

    // Apply one input cycle, then settle just after the capturing edge.
    task automatic drive(input logic v, input logic sof, input int re, input int im);
        in_valid = v;
        in_sof   = sof;
        in_re    = W'(re);
        in_im    = W'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic check_s0(input string tag, input int e, input int re, input int im, input int sof);
        chk({tag, "_mm"},  int'(s0_mm), int'(e == 0));
        chk({tag, "_wre"}, int'(s0_rom_re), exp_re(e));
        chk({tag, "_wim"}, int'(s0_rom_im), exp_im(e));
        chk({tag, "_xre"}, int'(s0_x0_re), re);
        chk({tag, "_xim"}, int'(s0_x0_im), im);
        chk({tag, "_ov"},  int'(s0_ov), 1);
        chk({tag, "_sof"}, int'(s0_os), sof);
    endtask

    task automatic check_s1(input string tag, input int e, input int re);
        chk({tag, "_mm"},  int'(s1_mm), int'(e == 0));
        chk({tag, "_wre"}, int'(s1_rom_re), exp_re(e));
        chk({tag, "_wim"}, int'(s1_rom_im), exp_im(e));
        chk({tag, "_xre"}, int'(s1_x0_re), re);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_ov",  int'(s0_ov), 0);
        chk("por_mm",  int'(s0_mm), 1);
        chk("por_wre", int'(s0_rom_re), 0);
        chk("por_xre", int'(s0_x0_re), 0);
        rst_n = 1'b1;

        // Reset mid-stream, then restart with in_sof.
        drive(1, 1, 5, -5);
        check_s0("rst_a", 0, 5, -5, 1);
        drive(1, 0, 6, -6);
        drive(1, 0, 7, -7);
        check_s0("rst_b", 2, 7, -7, 0);
        rst_n = 1'b0;
        drive(1, 0, 8, -8);
        chk("rst_ov",  int'(s0_ov), 0);
        chk("rst_mm",  int'(s0_mm), 1);
        chk("rst_wre", int'(s0_rom_re), 0);
        chk("rst_wim", int'(s0_rom_im), 0);
        chk("rst_xre", int'(s0_x0_re), 0);
        chk("rst_xim", int'(s0_x0_im), 0);
        rst_n = 1'b1;
        drive(1, 1, 9, -9);
        check_s0("rst_c", 0, 9, -9, 1);
        drive(1, 0, 10, -10);
        check_s0("rst_d", 1, 10, -10, 0);

        // One full frame seen by STAGE 0, 1 and 3.
        for (int i = 0; i < 16; i++) begin
            drive(1, i == 0, 3 * i + 1, -i);
            check_s0($sformatf("frm%0d", i), i, 3 * i + 1, -i, int'(i == 0));
            check_s1($sformatf("frm_s1_%0d", i), 2 * (i % 8), 3 * i + 1);
            chk($sformatf("frm_s3_mm%0d", i), int'(s3_mm), int'(i % 2 == 0));
            if (i % 2 == 1) begin
                chk($sformatf("frm_s3_wre%0d", i), int'(s3_rom_re), 0);
                chk($sformatf("frm_s3_wim%0d", i), int'(s3_rom_im), -256);
            end
        end

        // STAGE 1 with two idle cycles after every valid sample.
        for (int n = 0; n < 16; n++) begin
            drive(1, n == 0, 20 + n, n);
            check_s1($sformatf("gap%0d", n), 2 * (n % 8), 20 + n);
            chk($sformatf("gap_ov%0d", n), int'(s1_ov), 1);
            for (int g = 0; g < 2; g++) begin
                drive(0, 0, 100 + g, 100);
                chk($sformatf("gap_idle_ov%0d_%0d", n, g), int'(s1_ov), 0);
                chk($sformatf("gap_idle_sof%0d_%0d", n, g), int'(s1_os), 0);
                check_s1($sformatf("gap_hold%0d_%0d", n, g), 2 * (n % 8), 20 + n);
            end
        end

        // Mid-frame in_sof at k=5 resyncs to index 0.
        drive(1, 1, 1, 1);
        for (int i = 1; i < 5; i++) drive(1, 0, i, i);
        check_s0("rsy_pre", 4, 4, 4, 0);
        drive(1, 1, 40, -40);
        check_s0("rsy_sof", 0, 40, -40, 1);
        drive(1, 0, 41, -41);
        check_s0("rsy_nxt", 1, 41, -41, 0);

        // Two back-to-back frames: e=15 then e=0 with no bubble.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                drive(1, i == 0, 50 + i, f);
                check_s0($sformatf("b2b%0d_%0d", f, i), i, 50 + i, f, int'(i == 0));
            end
        end

        // in_sof without in_valid leaves the counter alone.
        drive(1, 1, 2, 2);
        drive(1, 0, 3, 3);
        drive(0, 1, 4, 4);
        chk("nosof_ov",  int'(s0_ov), 0);
        chk("nosof_sof", int'(s0_os), 0);
        drive(1, 0, 5, 5);
        check_s0("nosof_k", 2, 5, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
